// File: rtl/ctrl_decode_stage_pkg.sv
// ctrl_pkg: shared definitions for the ID/EXE decode stage.
//   - opcode values (OP_*) as carried on in_opcode
//   - ALU command encodings (EXE_*) for out_exe_cmd
//   - branch type encodings (BR_*) for out_branch_type
//   - ctrl_t: the decoded control bundle held in the ID/EXE register
//   - stage_state_e: stage FSM states
package ctrl_pkg;

   localparam int unsigned OP_NOP  = 0;
   localparam int unsigned OP_ADD  = 1;
   localparam int unsigned OP_SUB  = 3;
   localparam int unsigned OP_AND  = 5;
   localparam int unsigned OP_OR   = 6;
   localparam int unsigned OP_NOR  = 7;
   localparam int unsigned OP_XOR  = 8;
   localparam int unsigned OP_SLA  = 9;
   localparam int unsigned OP_SLL  = 10;
   localparam int unsigned OP_SRA  = 11;
   localparam int unsigned OP_SRL  = 12;
   localparam int unsigned OP_ADDI = 32;
   localparam int unsigned OP_SUBI = 33;
   localparam int unsigned OP_LD   = 36;
   localparam int unsigned OP_ST   = 37;
   localparam int unsigned OP_BEZ  = 40;
   localparam int unsigned OP_BNE  = 41;
   localparam int unsigned OP_JMP  = 42;

   localparam logic [3:0] EXE_ADD = 4'd0;
   localparam logic [3:0] EXE_SUB = 4'd2;
   localparam logic [3:0] EXE_AND = 4'd4;
   localparam logic [3:0] EXE_OR  = 4'd5;
   localparam logic [3:0] EXE_NOR = 4'd6;
   localparam logic [3:0] EXE_XOR = 4'd7;
   localparam logic [3:0] EXE_SHL = 4'd8;
   localparam logic [3:0] EXE_SRA = 4'd9;
   localparam logic [3:0] EXE_SRL = 4'd10;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_BEZ  = 2'd1;
   localparam logic [1:0] BR_BNE  = 2'd2;
   localparam logic [1:0] BR_JMP  = 2'd3;

   // ALU commands all fit in 4 bits; wider EXE_CMD_W ports zero-extend.
   typedef struct packed {
      logic [3:0] exe_cmd;
      logic [1:0] branch_type;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       is_imm;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } stage_state_e;

endpackage

// File: rtl/ctrl_decode_stage_lut.sv
// ctrl_decode_lut: purely combinational opcode decoder.
// Ports:
//   opcode    in   OPCODE_W  instruction opcode
//   ctrl      out  ctrl_t    decoded control bundle (all zero for NOP/illegal)
//   illegal   out  1         opcode is not in the decode map
//   src2_used out  1         instruction reads its second source register
module ctrl_decode_lut
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_t               ctrl,
   output logic                illegal,
   output logic                src2_used
);

   logic [31:0] op_val;
   assign op_val = 32'(opcode);

   always_comb begin
      ctrl      = CTRL_NONE;
      illegal   = 1'b0;
      src2_used = 1'b0;
      case (op_val)
         OP_NOP: ;
         OP_ADD: begin ctrl.exe_cmd = EXE_ADD; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_SUB: begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_AND: begin ctrl.exe_cmd = EXE_AND; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_OR:  begin ctrl.exe_cmd = EXE_OR;  ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_NOR: begin ctrl.exe_cmd = EXE_NOR; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_XOR: begin ctrl.exe_cmd = EXE_XOR; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         // arithmetic and logical left shift share one ALU command
         OP_SLA: begin ctrl.exe_cmd = EXE_SHL; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_SLL: begin ctrl.exe_cmd = EXE_SHL; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_SRA: begin ctrl.exe_cmd = EXE_SRA; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_SRL: begin ctrl.exe_cmd = EXE_SRL; ctrl.wb_en = 1'b1; src2_used = 1'b1; end
         OP_ADDI: begin
            ctrl.exe_cmd = EXE_ADD;
            ctrl.wb_en   = 1'b1;
            ctrl.is_imm  = 1'b1;
         end
         OP_SUBI: begin
            ctrl.exe_cmd = EXE_SUB;
            ctrl.wb_en   = 1'b1;
            ctrl.is_imm  = 1'b1;
         end
         OP_LD: begin
            ctrl.exe_cmd  = EXE_ADD;
            ctrl.is_imm   = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.wb_en    = 1'b1;
         end
         // store data comes from src2, so it counts for hazard detection
         OP_ST: begin
            ctrl.exe_cmd   = EXE_ADD;
            ctrl.is_imm    = 1'b1;
            ctrl.mem_write = 1'b1;
            src2_used      = 1'b1;
         end
         OP_BEZ: begin ctrl.branch_type = BR_BEZ; src2_used = 1'b1; end
         OP_BNE: begin ctrl.branch_type = BR_BNE; src2_used = 1'b1; end
         OP_JMP: ctrl.branch_type = BR_JMP;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered opcode decode and ID/EXE pipeline register
// with valid/ready handshake, flush and single-bubble load-use stall.
//
// Optional build macro: CTRL_PERF_CNT_EN adds saturating stall_cnt and
// illegal_cnt outputs.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   in_opcode, in_dest,
//   in_src1, in_src2, in_pc   incoming instruction fields
//   flush                     kill held and incoming instruction
//   out_valid / out_ready     downstream handshake
//   out_exe_cmd, out_branch_type, out_mem_read, out_mem_write,
//   out_wb_en, out_is_imm     registered control bundle
//   out_dest, out_src1,
//   out_src2, out_pc          registered instruction fields
//   out_illegal               registered illegal-opcode flag
//   stall_o                   load-use hazard this cycle (combinational)
//   stall_cnt, illegal_cnt    (CTRL_PERF_CNT_EN only) event counters
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_RUN    | normal flow; a load-use hazard loads a bubble
// ST_BUBBLE | bubble is in the output register; next input flows normally
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W   = 6,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32,
   parameter int EXE_CMD_W  = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OPCODE_W-1:0]   in_opcode,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [REG_ADDR_W-1:0] in_src1,
   input  logic [REG_ADDR_W-1:0] in_src2,
   input  logic [PC_W-1:0]       in_pc,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXE_CMD_W-1:0]  out_exe_cmd,
   output logic [1:0]            out_branch_type,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_wb_en,
   output logic                  out_is_imm,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic [REG_ADDR_W-1:0] out_src1,
   output logic [REG_ADDR_W-1:0] out_src2,
   output logic [PC_W-1:0]       out_pc,
   output logic                  out_illegal,
   output logic                  stall_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      illegal_cnt
`endif
);

   stage_state_e state;
   ctrl_t        out_ctrl;
   ctrl_t        dec_ctrl;
   logic         dec_illegal;
   logic         dec_src2_used;
   logic         load_en;
   logic         hazard;
   logic         accept;

   ctrl_decode_lut #(
      .OPCODE_W (OPCODE_W)
   ) u_lut (
      .opcode    (in_opcode),
      .ctrl      (dec_ctrl),
      .illegal   (dec_illegal),
      .src2_used (dec_src2_used)
   );

   // Load from memory writes back one cycle too late for a consumer that
   // reads it in the very next slot; writes to r0 are never a dependency.
   assign hazard = in_valid && out_valid && out_ctrl.mem_read &&
                   (out_dest != '0) &&
                   ((in_src1 == out_dest) || (dec_src2_used && (in_src2 == out_dest)));

   assign load_en  = !out_valid || out_ready;
   assign in_ready = load_en && !hazard && !flush;
   assign accept   = in_valid && in_ready;
   assign stall_o  = hazard;

   assign out_exe_cmd     = EXE_CMD_W'(out_ctrl.exe_cmd);
   assign out_branch_type = out_ctrl.branch_type;
   assign out_mem_read    = out_ctrl.mem_read;
   assign out_mem_write   = out_ctrl.mem_write;
   assign out_wb_en       = out_ctrl.wb_en;
   assign out_is_imm      = out_ctrl.is_imm;

   // Flush and bubbles leave the whole register cleared so nothing from the
   // killed instruction lingers on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         out_valid   <= 1'b0;
         out_ctrl    <= CTRL_NONE;
         out_illegal <= 1'b0;
         out_dest    <= '0;
         out_src1    <= '0;
         out_src2    <= '0;
         out_pc      <= '0;
      end else if (flush) begin
         state       <= ST_RUN;
         out_valid   <= 1'b0;
         out_ctrl    <= CTRL_NONE;
         out_illegal <= 1'b0;
         out_dest    <= '0;
         out_src1    <= '0;
         out_src2    <= '0;
         out_pc      <= '0;
      end else if (load_en) begin
         case (state)
            ST_RUN: state <= hazard ? ST_BUBBLE : ST_RUN;
            default: state <= ST_RUN;
         endcase
         out_valid <= accept;
         if (accept) begin
            out_ctrl    <= dec_ctrl;
            out_illegal <= dec_illegal;
            out_dest    <= in_dest;
            out_src1    <= in_src1;
            out_src2    <= in_src2;
            out_pc      <= in_pc;
         end else begin
            out_ctrl    <= CTRL_NONE;
            out_illegal <= 1'b0;
            out_dest    <= '0;
            out_src1    <= '0;
            out_src2    <= '0;
            out_pc      <= '0;
         end
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic stall_evt;
   logic illegal_evt;

   assign stall_evt   = !flush && load_en && hazard;
   assign illegal_evt = accept && dec_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt   <= '0;
         illegal_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (illegal_evt && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
